// File: rtl/alu_result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_result_buffer_if
// Brief   : Producer/consumer handshake bundle for the ALU result buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_result_buffer_if #(
  parameter int WIDTH = 4,
  parameter int N_ALU = 4,
  parameter int DEPTH = 8
);
  localparam int RW = WIDTH * N_ALU * 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_result;
  logic          in_carry;
  logic          in_gt;
  logic          in_eq;
  logic          in_lt;
  logic [2:0]    in_select;

  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;
  logic          out_carry;
  logic [2:0]    out_flags;
  logic [2:0]    out_select;

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          flag_err;
  logic [15:0]   push_total;

  modport master (
    output in_valid, in_result, in_carry, in_gt, in_eq, in_lt, in_select, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_flags, out_select,
    input  count, full, empty, flag_err, push_total
  );

  modport slave (
    input  in_valid, in_result, in_carry, in_gt, in_eq, in_lt, in_select, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_flags, out_select,
    output count, full, empty, flag_err, push_total
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : alu_result_buffer
// Brief   : FWFT FIFO capturing ALU results, with compare-flag integrity check.
// Revision: 1.0 - initial release
// ============================================================================
module alu_result_buffer #(
  parameter int WIDTH = 4,
  parameter int N_ALU = 4,
  parameter int DEPTH = 8
) (
  input wire                 clk,
  input wire                 arst,
  alu_result_buffer_if.slave bus
);
  localparam int RW   = WIDTH * N_ALU * 8;
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_EW = RW + 7;
  localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);

  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            r_flag_err;
  logic [15:0]     r_push_total;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [2:0]      w_in_flags;
  logic            w_flags_bad;
  logic [c_EW-1:0] w_head;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);

  // in_ready ignores out_ready: a full buffer refuses even when popping.
  assign bus.in_ready  = !w_full && !arst;
  assign bus.out_valid = !w_empty;

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  assign w_in_flags  = {bus.in_gt, bus.in_eq, bus.in_lt};
  assign w_flags_bad = !((w_in_flags == 3'b100) || (w_in_flags == 3'b010) ||
                         (w_in_flags == 3'b001));

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_result, bus.in_carry, w_in_flags, bus.in_select};
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_flag_err   <= 1'b0;
      r_push_total <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_flags_bad) begin
        r_flag_err <= 1'b1;
      end
      if (w_push && (r_push_total != 16'hFFFF)) begin
        r_push_total <= r_push_total + 16'd1;
      end
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.out_result = w_empty ? '0   : w_head[c_EW-1 -: RW];
  assign bus.out_carry  = w_empty ? 1'b0 : w_head[6];
  assign bus.out_flags  = w_empty ? 3'b0 : w_head[5:3];
  assign bus.out_select = w_empty ? 3'b0 : w_head[2:0];

  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.flag_err   = r_flag_err;
  assign bus.push_total = r_push_total;
endmodule
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_result_buffer
// Brief   : Table-driven, scoreboard-checked bench for alu_result_buffer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_result_buffer;
  localparam int WIDTH = 4;
  localparam int N_ALU = 4;
  localparam int DEPTH = 8;
  localparam int RW    = WIDTH * N_ALU * 8;

  typedef struct {
    logic [RW-1:0] res;
    logic          carry;
    logic [2:0]    flags;
    logic [2:0]    sel;
  } ent_t;

  typedef struct {
    bit          v;
    logic [15:0] res;
    logic [2:0]  fl;
    logic [2:0]  sel;
    bit          rdy;
    int          exp_count;
  } vec_t;

  logic clk = 1'b0;
  logic arst = 1'b0;

  alu_result_buffer_if #(.WIDTH(WIDTH), .N_ALU(N_ALU), .DEPTH(DEPTH)) bus ();

  alu_result_buffer #(.WIDTH(WIDTH), .N_ALU(N_ALU), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t sb[$];
  vec_t vt[$];
  int   m_count  = 0;
  int   m_total  = 0;
  bit   m_ferr   = 1'b0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit v, input logic [15:0] res, input logic [2:0] fl,
                              input logic [2:0] sel, input bit rdy, input int exp_count);
    vec_t r;
    r.v = v; r.res = res; r.fl = fl; r.sel = sel; r.rdy = rdy; r.exp_count = exp_count;
    vt.push_back(r);
  endfunction

  function automatic bit flags_bad(input logic [2:0] fl);
    return (fl != 3'b100) && (fl != 3'b010) && (fl != 3'b001);
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_count = 0;
    m_total = 0;
    m_ferr  = 1'b0;
  endfunction

  // One clock of stimulus: head/handshake checked before the edge, state after.
  task automatic run_cycle(input bit v, input logic [15:0] r, input logic [2:0] fl,
                           input logic [2:0] sel, input bit rdy, input int exp_count);
    bit   exp_push;
    bit   exp_pop;
    ent_t e;
    bus.in_valid  = v;
    bus.in_result = {8{r}};
    bus.in_carry  = r[0];
    {bus.in_gt, bus.in_eq, bus.in_lt} = fl;
    bus.in_select = sel;
    bus.out_ready = rdy;
    #1;
    exp_push = v && (m_count < DEPTH);
    exp_pop  = rdy && (m_count > 0);
    chk("in_ready", bus.in_ready, m_count < DEPTH);
    chk("out_valid", bus.out_valid, m_count > 0);
    if (m_count > 0) begin
      chk("head_result", bus.out_result, sb[0].res);
      chk("head_carry", bus.out_carry, sb[0].carry);
      chk("head_flags", bus.out_flags, sb[0].flags);
      chk("head_select", bus.out_select, sb[0].sel);
    end else begin
      chk("empty_result", bus.out_result, '0);
    end
    @(posedge clk);
    #1;
    if (exp_pop) void'(sb.pop_front());
    if (exp_push) begin
      e.res = {8{r}}; e.carry = r[0]; e.flags = fl; e.sel = sel;
      sb.push_back(e);
      if (m_total < 16'hFFFF) m_total++;
      if (flags_bad(fl)) m_ferr = 1'b1;
    end
    m_count = m_count + int'(exp_push) - int'(exp_pop);
    chk("count", bus.count, exp_count);
    chk("full", bus.full, exp_count == DEPTH);
    chk("empty", bus.empty, exp_count == 0);
    chk("flag_err", bus.flag_err, m_ferr);
    chk("push_total", bus.push_total, m_total);
  endtask

  task automatic do_reset(input int cycles);
    arst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      #1;
      chk("in_ready_in_reset", bus.in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    model_reset();
    arst = 1'b0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_result", bus.out_result, '0);
    chk("rst_flag_err", bus.flag_err, 1'b0);
    chk("rst_push_total", bus.push_total, 16'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_carry = 1'b0;
    bus.in_gt = 1'b0; bus.in_eq = 1'b0; bus.in_lt = 1'b0;
    bus.in_select = 3'd0; bus.out_ready = 1'b0;

    // Single pass, fill/wrap with refused 9th push, push+pop at count 4, pop at full.
    add(1, 16'h1234, 3'b100, 3'd2, 0, 1);
    add(0, 16'h0, 3'b000, 3'd0, 0, 1);
    add(0, 16'h0, 3'b000, 3'd0, 1, 0);
    for (int k = 1; k <= 8; k++) add(1, 16'(k), 3'b001 << (k % 3), 3'(k), 0, k);
    add(1, 16'd9, 3'b001, 3'd1, 0, 8);
    for (int k = 1; k <= 3; k++) add(0, 16'h0, 3'b000, 3'd0, 1, 8 - k);
    for (int k = 9; k <= 11; k++) add(1, 16'(k), 3'b010, 3'(k), 0, k - 3);
    for (int k = 1; k <= 6; k++) add(0, 16'h0, 3'b000, 3'd0, 1, 8 - k);
    add(1, 16'd12, 3'b100, 3'd4, 0, 3);
    add(1, 16'd13, 3'b001, 3'd5, 0, 4);
    add(1, 16'd14, 3'b010, 3'd6, 1, 4);
    for (int k = 15; k <= 18; k++) add(1, 16'(k), 3'b100, 3'(k), 0, k - 10);
    add(1, 16'd19, 3'b001, 3'd7, 1, 7);
    add(1, 16'd19, 3'b001, 3'd7, 0, 8);
    for (int k = 1; k <= 8; k++) add(0, 16'h0, 3'b000, 3'd0, 1, 8 - k);

    @(posedge clk);
    #1;
    do_reset(2);

    foreach (vt[i]) run_cycle(vt[i].v, vt[i].res, vt[i].fl, vt[i].sel, vt[i].rdy, vt[i].exp_count);
    chk("sb_drained", sb.size(), 0);

    // Flag integrity: bad flags stored, sticky through drain, cleared by reset.
    run_cycle(1, 16'h0ABC, 3'b110, 3'd5, 0, 1);
    chk("flag_err_set", bus.flag_err, 1'b1);
    run_cycle(0, 16'h0, 3'b000, 3'd0, 1, 0);
    run_cycle(0, 16'h0, 3'b000, 3'd0, 0, 0);
    chk("flag_err_sticky", bus.flag_err, 1'b1);
    run_cycle(1, 16'h0F0F, 3'b000, 3'd1, 0, 1);
    do_reset(1);

    // Mid-stream reset with push+pop active.
    for (int k = 1; k <= 5; k++) run_cycle(1, 16'(16'h100 + k), 3'b010, 3'(k), 0, k);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    do_reset(1);

    // Saturation of push_total with continuous push+pop.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_result = '0;
    {bus.in_gt, bus.in_eq, bus.in_lt} = 3'b010;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    chk("push_total_fffe", bus.push_total, 16'hFFFE);
    chk("stream_count", bus.count, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("push_total_sat", bus.push_total, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("push_total_hold", bus.push_total, 16'hFFFF);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
